seq010_tx: RTL and testbench

//   Serial "010" pattern transmitter: the driving end of the 010 detector link.
//   On a start request it emits a burst of N "010" patterns on a one-bit serial line.

---
 rtl/seq010_tx.sv | 118 +++++++++++
 tb/tb_seq010_tx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq010_tx.sv
// Serial "010" burst transmitter: sends n_pat "010" patterns separated by idle-high gap bits.
// Optional SEQ010_TX_OVERLAP_EN: consecutive patterns share the boundary zero, with no gap.
module seq010_tx #(
    parameter int unsigned GAP_BITS = 1,
    parameter int unsigned CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_pat,
    output logic             xout,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_B0,
        S_B1,
        S_B2,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] npat_q, npat_d;
    logic [CNT_W-1:0] cnt_inc;

`ifndef SEQ010_TX_OVERLAP_EN
    localparam int unsigned GW_RAW = $clog2(GAP_BITS + 1);
    localparam int unsigned GW     = (GW_RAW < 1) ? 1 : GW_RAW;

    logic [GW-1:0] gap_q, gap_d;
`endif

    assign cnt_inc = count_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            npat_q  <= '0;
`ifndef SEQ010_TX_OVERLAP_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            npat_q  <= npat_d;
`ifndef SEQ010_TX_OVERLAP_EN
            gap_q   <= gap_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        npat_d  = npat_q;
`ifndef SEQ010_TX_OVERLAP_EN
        gap_d   = gap_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d = '0;
                    if (n_pat != '0) begin
                        npat_d  = n_pat;
                        state_d = S_B0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_B0: state_d = S_B1;
            S_B1: state_d = S_B2;
            S_B2: begin
                // Comparing the incremented value lets n_pat = 2^CNT_W-1 finish without wrapping.
                count_d = cnt_inc;
                if (cnt_inc == npat_q) begin
                    state_d = S_DONE;
                end else begin
`ifdef SEQ010_TX_OVERLAP_EN
                    state_d = S_B1;
`else
                    if (GAP_BITS > 0) begin
                        gap_d   = GW'(GAP_BITS);
                        state_d = S_GAP;
                    end else begin
                        state_d = S_B0;
                    end
`endif
                end
            end
            S_GAP: begin
`ifndef SEQ010_TX_OVERLAP_EN
                if (gap_q <= GW'(1)) begin
                    state_d = S_B0;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
`else
                state_d = S_B1;
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign xout  = !((state_q == S_B0) || (state_q == S_B2));
    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign count = count_q;

endmodule

// File: tb/tb_seq010_tx.sv
// Directed bench for seq010_tx: instance A (GAP_BITS=1, CNT_W=10) and instance B (GAP_BITS=0, CNT_W=3).
// Build with SEQ010_TX_OVERLAP_EN defined to exercise the overlapping variant.
module tb_seq010_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_a, start_b;
    logic [9:0] npat_a, cnt_a;
    logic [2:0] npat_b, cnt_b;
    logic       xout_a, busy_a, done_a;
    logic       xout_b, busy_b, done_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq010_tx #(.GAP_BITS(1), .CNT_W(10)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .n_pat(npat_a),
        .xout(xout_a), .busy(busy_a), .done(done_a), .count(cnt_a)
    );

    seq010_tx #(.GAP_BITS(0), .CNT_W(3)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .n_pat(npat_b),
        .xout(xout_b), .busy(busy_b), .done(done_b), .count(cnt_b)
    );

`ifdef SEQ010_TX_OVERLAP_EN
    // Loopback model of an overlapping 010 detector on instance A's line.
    int         det_cnt = 0;
    logic [1:0] det_sh  = 2'b11;
    always @(negedge clk) begin
        if ({det_sh, xout_a} == 3'b010) det_cnt <= det_cnt + 1;
        det_sh <= {det_sh[0], xout_a};
    end
`endif

    typedef struct {
        logic       st;
        logic [9:0] n;
        logic       x;
        logic       b;
        logic       d;
        logic [9:0] c;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic st, input logic [9:0] n, input logic x,
                                input logic b, input logic d, input logic [9:0] c);
        vec_t v;
        v.st = st; v.n = n; v.x = x; v.b = b; v.d = d; v.c = c;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Caller has already set start_a/npat_a; a stray start pulse is injected mid-burst.
    task automatic run_a(input string tag, input int exp_cyc, input int exp_cnt);
        int n;
        int base;
        n = 0;
`ifdef SEQ010_TX_OVERLAP_EN
        #1 base = det_cnt;
`else
        base = 0;
`endif
        do begin
            @(negedge clk);
            n++;
            start_a = (n == 3);
        end while (!done_a && n < 60);
        start_a = 1'b0;
        chk({tag, "_done_seen"}, done_a, 1);
        chk({tag, "_cycles"}, n, exp_cyc);
        chk({tag, "_count"}, cnt_a, exp_cnt);
        chk({tag, "_done_xout"}, xout_a, 1);
`ifdef SEQ010_TX_OVERLAP_EN
        #1 chk({tag, "_detector"}, det_cnt - base, exp_cnt);
`endif
        @(negedge clk);
        chk({tag, "_busy_end"}, busy_a, 0);
        chk({tag, "_done_end"}, done_a, 0);
    endtask

    initial begin
        int ex_x[$];
        int ex_c[$];
        int n;
        int bad;
        logic [2:0] prev;

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; npat_a = '0; npat_b = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_xout_a", xout_a, 1); chk("idle_busy_a", busy_a, 0);
            chk("idle_done_a", done_a, 0); chk("idle_cnt_a", cnt_a, 0);
            chk("idle_xout_b", xout_b, 1); chk("idle_busy_b", busy_b, 0);
            chk("idle_done_b", done_b, 0); chk("idle_cnt_b", cnt_b, 0);
        end

        // n_pat=3 burst with ignored start pulses and n_pat changes
        add(1, 3, 0, 1, 0, 0);
        add(0, 3, 1, 1, 0, 0);
        add(1, 5, 0, 1, 0, 0);
`ifdef SEQ010_TX_OVERLAP_EN
        add(0, 7, 1, 1, 0, 1);
        add(0, 3, 0, 1, 0, 1);
        add(1, 0, 1, 1, 0, 2);
        add(0, 3, 0, 1, 0, 2);
`else
        add(0, 7, 1, 1, 0, 1);
        add(0, 3, 0, 1, 0, 1);
        add(1, 0, 1, 1, 0, 1);
        add(0, 3, 0, 1, 0, 1);
        add(0, 3, 1, 1, 0, 2);
        add(0, 3, 0, 1, 0, 2);
        add(0, 3, 1, 1, 0, 2);
        add(0, 3, 0, 1, 0, 2);
`endif
        add(0, 3, 1, 1, 1, 3);
        add(0, 3, 1, 0, 0, 3);
        add(0, 3, 1, 0, 0, 3);
        // n_pat=0: a single DONE cycle, count cleared
        add(1, 0, 1, 1, 1, 0);
        add(0, 0, 1, 0, 0, 0);
        // start held through DONE restarts from IDLE
        add(1, 1, 0, 1, 0, 0);
        add(1, 1, 1, 1, 0, 0);
        add(1, 1, 0, 1, 0, 0);
        add(1, 1, 1, 1, 1, 1);
        add(1, 1, 1, 0, 0, 1);
        add(1, 1, 0, 1, 0, 0);
        add(0, 1, 1, 1, 0, 0);
        add(0, 1, 0, 1, 0, 0);
        add(0, 1, 1, 1, 1, 1);
        add(0, 1, 1, 0, 0, 1);

        foreach (vecs[i]) begin
            start_a = vecs[i].st;
            npat_a  = vecs[i].n;
            @(negedge clk);
            chk($sformatf("tbl%0d_xout", i), xout_a, vecs[i].x);
            chk($sformatf("tbl%0d_busy", i), busy_a, vecs[i].b);
            chk($sformatf("tbl%0d_done", i), done_a, vecs[i].d);
            chk($sformatf("tbl%0d_count", i), cnt_a, vecs[i].c);
        end
        start_a = 1'b0;

        // Instance B, GAP_BITS=0, n_pat=2
`ifdef SEQ010_TX_OVERLAP_EN
        ex_x = '{0, 1, 0, 1, 0};
        ex_c = '{0, 0, 0, 1, 1};
`else
        ex_x = '{0, 1, 0, 0, 1, 0};
        ex_c = '{0, 0, 0, 1, 1, 1};
`endif
        start_b = 1'b1; npat_b = 3'd2;
        foreach (ex_x[i]) begin
            @(negedge clk);
            start_b = (i == 1);
            chk($sformatf("b2_xout%0d", i), xout_b, ex_x[i]);
            chk($sformatf("b2_count%0d", i), cnt_b, ex_c[i]);
            chk($sformatf("b2_busy%0d", i), busy_b, 1);
            chk($sformatf("b2_done%0d", i), done_b, 0);
        end
        start_b = 1'b0;
        @(negedge clk);
        chk("b2_done", done_b, 1); chk("b2_done_xout", xout_b, 1); chk("b2_final", cnt_b, 2);
        @(negedge clk);
        chk("b2_busy_end", busy_b, 0); chk("b2_done_once", done_b, 0); chk("b2_hold", cnt_b, 2);

        // Instance B, maximum n_pat = 7 for CNT_W=3: reaches 7 exactly, no wrap
        start_b = 1'b1; npat_b = 3'd7;
        n = 0; bad = 0; prev = '0;
        do begin
            @(negedge clk);
            start_b = 1'b0;
            n++;
            if (cnt_b < prev) bad++;
            prev = cnt_b;
        end while (!done_b && n < 60);
        chk("bmax_done_seen", done_b, 1);
`ifdef SEQ010_TX_OVERLAP_EN
        chk("bmax_cycles", n, 16);
`else
        chk("bmax_cycles", n, 22);
`endif
        chk("bmax_count", cnt_b, 7);
        chk("bmax_monotonic", bad, 0);
        @(negedge clk);

        // Reset during B1 of the second pattern
        start_a = 1'b1; npat_a = 10'd3;
        @(negedge clk);
        start_a = 1'b0;
`ifdef SEQ010_TX_OVERLAP_EN
        repeat (3) @(negedge clk);
`else
        repeat (5) @(negedge clk);
`endif
        chk("rst_pre_xout", xout_a, 1); chk("rst_pre_count", cnt_a, 1); chk("rst_pre_busy", busy_a, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_xout", xout_a, 1); chk("rst_async_busy", busy_a, 0);
        chk("rst_async_done", done_a, 0); chk("rst_async_count", cnt_a, 0);
        @(negedge clk);
        chk("rst_held_xout", xout_a, 1); chk("rst_held_count", cnt_a, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_idle_busy", busy_a, 0);

        // Clean burst after reset, n_pat=3
        start_a = 1'b1; npat_a = 10'd3;
`ifdef SEQ010_TX_OVERLAP_EN
        run_a("post_rst", 8, 3);
`else
        run_a("post_rst", 12, 3);
`endif

        // Longer burst, n_pat=5
        start_a = 1'b1; npat_a = 10'd5;
`ifdef SEQ010_TX_OVERLAP_EN
        run_a("burst5", 12, 5);
`else
        run_a("burst5", 20, 5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
